// File: rtl/eth_pkt_pkg.sv
// Ethernet/ARP constants, byte offsets and FSM state type for the ARP RX parser.
// Offsets are byte indices from the first byte of the Ethernet destination MAC.
package eth_pkt_pkg;

  localparam logic [15:0] ETH_TYPE_ARP   = 16'h0806;
  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ARP_OPER_REQ   = 16'd1;
  localparam logic [15:0] ARP_OPER_REPLY = 16'd2;
  localparam logic [7:0]  ARP_HLEN_ETH   = 8'd6;
  localparam logic [7:0]  ARP_PLEN_IPV4  = 8'd4;

  localparam logic [5:0] DMAC_OFF  = 6'd0;
  localparam logic [5:0] ETYPE_OFF = 6'd12;
  localparam logic [5:0] HTYPE_OFF = 6'd14;
  localparam logic [5:0] PTYPE_OFF = 6'd16;
  localparam logic [5:0] HLEN_OFF  = 6'd18;
  localparam logic [5:0] PLEN_OFF  = 6'd19;
  localparam logic [5:0] OPER_OFF  = 6'd20;
  localparam logic [5:0] SHA_OFF   = 6'd22;
  localparam logic [5:0] SPA_OFF   = 6'd28;
  localparam logic [5:0] THA_OFF   = 6'd32;
  localparam logic [5:0] TPA_OFF   = 6'd38;

  typedef enum logic [1:0] {IDLE, HDR, DROP, DONE} arp_rx_state_t;

  // Byte i of a MAC address, MSB first (i=0 is bits 47:40).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] i);
    case (i)
      3'd0:    mac_byte = mac[47:40];
      3'd1:    mac_byte = mac[39:32];
      3'd2:    mac_byte = mac[31:24];
      3'd3:    mac_byte = mac[23:16];
      3'd4:    mac_byte = mac[15:8];
      3'd5:    mac_byte = mac[7:0];
      default: mac_byte = 8'h00;
    endcase
  endfunction

  // Byte i of an IPv4 address, MSB first.
  function automatic logic [7:0] ip_byte(input logic [31:0] ip, input logic [1:0] i);
    case (i)
      2'd0:    ip_byte = ip[31:24];
      2'd1:    ip_byte = ip[23:16];
      2'd2:    ip_byte = ip[15:8];
      default: ip_byte = ip[7:0];
    endcase
  endfunction

endpackage

// File: rtl/arp_rx_parser.sv
// ARP receive parser. Checks Ethernet/ARP header fields in flight by byte
// index, captures sender MAC/IP, and one cycle after the last byte pulses
// either arp_rx_valid (accepted, outputs updated) or arp_drop (rejected).
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   local_mac, local_ip     this node's addresses (quasi-static)
//   rx_data/valid/last/err  received byte stream, no backpressure
//   arp_src_mac/ip          sender addresses of the last accepted frame
//   arp_rx_valid            accept strobe; arp_is_request valid with it
//   arp_drop                reject strobe
// Optional (macro ARP_RX_STATS_EN): stat_clr input, stat_accept_cnt and
// stat_drop_cnt 16-bit wrapping counters of the two strobes.
module arp_rx_parser
  import eth_pkt_pkg::*;
#(
  parameter bit CHECK_TPA = 1'b1,
  parameter int MIN_LEN   = 42
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] local_mac,
  input  logic [31:0] local_ip,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_last,
  input  logic        rx_err,
`ifdef ARP_RX_STATS_EN
  input  logic        stat_clr,
  output logic [15:0] stat_accept_cnt,
  output logic [15:0] stat_drop_cnt,
`endif
  output logic [47:0] arp_src_mac,
  output logic [31:0] arp_src_ip,
  output logic        arp_rx_valid,
  output logic        arp_is_request,
  output logic        arp_drop
);

  arp_rx_state_t state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        bc_q, bc_d, uc_q, uc_d;   // dest MAC still matches broadcast / local
  logic [47:0] sha_q, sha_d;
  logic [31:0] spa_q, spa_d;
  logic        req_q, req_d;
  logic [47:0] mac_q;
  logic [31:0] ip_q;
  logic        vld_q, isreq_q, drop_q;
  logic [5:0]  idx;
  logic        fail, last_beat, accept;

  assign idx = cnt_q;

  // Per-byte field check for the byte currently on rx_data.
  always_comb begin
    fail = 1'b0;
    bc_d = bc_q;
    uc_d = uc_q;
    if (idx <= DMAC_OFF + 6'd5) begin
      // Track both candidate addresses so a mix of ff and local bytes fails.
      bc_d = (idx == DMAC_OFF || bc_q) && rx_data == 8'hff;
      uc_d = (idx == DMAC_OFF || uc_q) && rx_data == mac_byte(local_mac, 3'(idx - DMAC_OFF));
      fail = !bc_d && !uc_d;
    end
    case (idx)
      ETYPE_OFF:         fail = rx_data != ETH_TYPE_ARP[15:8];
      ETYPE_OFF + 6'd1:  fail = rx_data != ETH_TYPE_ARP[7:0];
      HTYPE_OFF:         fail = rx_data != ARP_HTYPE_ETH[15:8];
      HTYPE_OFF + 6'd1:  fail = rx_data != ARP_HTYPE_ETH[7:0];
      PTYPE_OFF:         fail = rx_data != ARP_PTYPE_IPV4[15:8];
      PTYPE_OFF + 6'd1:  fail = rx_data != ARP_PTYPE_IPV4[7:0];
      HLEN_OFF:          fail = rx_data != ARP_HLEN_ETH;
      PLEN_OFF:          fail = rx_data != ARP_PLEN_IPV4;
      OPER_OFF:          fail = rx_data != ARP_OPER_REQ[15:8];
      OPER_OFF + 6'd1:   fail = rx_data != ARP_OPER_REQ[7:0] && rx_data != ARP_OPER_REPLY[7:0];
      default: ;
    endcase
    if (CHECK_TPA && idx >= TPA_OFF && idx <= TPA_OFF + 6'd3)
      fail = rx_data != ip_byte(local_ip, 2'(idx - TPA_OFF));
  end

  // Counter and shadow captures. Shadows only load at indices 22-31, so a
  // following frame cannot disturb them before its own accept.
  always_comb begin
    cnt_d = cnt_q;
    sha_d = sha_q;
    spa_d = spa_q;
    req_d = req_q;
    if (rx_valid) begin
      if (rx_last)              cnt_d = '0;
      else if (cnt_q != 6'h3f)  cnt_d = cnt_q + 6'd1;
      if (idx >= SHA_OFF && idx < SPA_OFF) sha_d = {sha_q[39:0], rx_data};
      if (idx >= SPA_OFF && idx < THA_OFF) spa_d = {spa_q[23:0], rx_data};
      if (idx == OPER_OFF + 6'd1)          req_d = rx_data == ARP_OPER_REQ[7:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (rx_valid) state_d = rx_last ? DONE : (fail ? DROP : HDR);
      HDR:        if (rx_valid) state_d = rx_last ? DONE : (fail ? DROP : HDR);
      DROP:       if (rx_valid && rx_last) state_d = DONE;
      default:    state_d = IDLE;
    endcase
    if (state_d == DONE && !(rx_valid && rx_last)) state_d = IDLE;
  end

  // Verdict is formed on the last beat and registered, so the strobe lands in
  // the DONE cycle. A runt's last index is below MIN_LEN-1 (counter is 0 when
  // the last beat arrives in IDLE/DONE).
  assign last_beat = rx_valid && rx_last;
  assign accept    = last_beat && state_q != DROP && !fail && !rx_err &&
                     int'(cnt_q) >= MIN_LEN - 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bc_q    <= 1'b0;
      uc_q    <= 1'b0;
      sha_q   <= '0;
      spa_q   <= '0;
      req_q   <= 1'b0;
      mac_q   <= '0;
      ip_q    <= '0;
      vld_q   <= 1'b0;
      isreq_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (rx_valid) begin
        bc_q <= bc_d;
        uc_q <= uc_d;
      end
      sha_q   <= sha_d;
      spa_q   <= spa_d;
      req_q   <= req_d;
      vld_q   <= accept;
      isreq_q <= accept && req_q;
      drop_q  <= last_beat && !accept;
      if (accept) begin
        mac_q <= sha_q;
        ip_q  <= spa_q;
      end
    end
  end

  assign arp_src_mac    = mac_q;
  assign arp_src_ip     = ip_q;
  assign arp_rx_valid   = vld_q;
  assign arp_is_request = isreq_q;
  assign arp_drop       = drop_q;

`ifdef ARP_RX_STATS_EN
  logic [15:0] acc_cnt_q, drp_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt_q <= '0;
      drp_cnt_q <= '0;
    end else if (stat_clr) begin
      acc_cnt_q <= '0;
      drp_cnt_q <= '0;
    end else begin
      if (vld_q)  acc_cnt_q <= acc_cnt_q + 16'd1;
      if (drop_q) drp_cnt_q <= drp_cnt_q + 16'd1;
    end
  end
  assign stat_accept_cnt = acc_cnt_q;
  assign stat_drop_cnt   = drp_cnt_q;
`endif

endmodule

// File: tb/tb_arp_rx_parser.sv
// Self-checking bench for arp_rx_parser: directed vector table, hand-written
// multi-cycle sequences (error + back-to-back, mid-frame reset, stats), and
// randomized frames checked against a whole-frame reference model.
module tb_arp_rx_parser;

  localparam logic [47:0] LMAC = 48'h02_11_22_33_44_55;
  localparam logic [31:0] LIP  = 32'hc0_a8_01_02;
  localparam logic [47:0] BC   = 48'hff_ff_ff_ff_ff_ff;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] local_mac = LMAC;
  logic [31:0] local_ip  = LIP;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0, rx_last = 1'b0, rx_err = 1'b0;
  logic [47:0] arp_src_mac;
  logic [31:0] arp_src_ip;
  logic        arp_rx_valid, arp_is_request, arp_drop;
`ifdef ARP_RX_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_accept_cnt, stat_drop_cnt;
`endif

  arp_rx_parser dut (
    .clk(clk), .rst_n(rst_n), .local_mac(local_mac), .local_ip(local_ip),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last), .rx_err(rx_err),
`ifdef ARP_RX_STATS_EN
    .stat_clr(stat_clr), .stat_accept_cnt(stat_accept_cnt), .stat_drop_cnt(stat_drop_cnt),
`endif
    .arp_src_mac(arp_src_mac), .arp_src_ip(arp_src_ip), .arp_rx_valid(arp_rx_valid),
    .arp_is_request(arp_is_request), .arp_drop(arp_drop)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int n_vld = 0, n_drop = 0, n_both = 0;
  int exp_acc_n = 0, exp_drop_n = 0;
  logic [47:0] hold_mac = '0;
  logic [31:0] hold_ip  = '0;

  // Strobe monitor: each cycle a strobe is high is counted once.
  always @(posedge clk) begin
    if (arp_rx_valid) n_vld++;
    if (arp_drop) n_drop++;
    if (arp_rx_valid && arp_drop) n_both++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic bq_t build(input logic [47:0] dst, input logic [15:0] et,
                                input logic [15:0] op, input logic [47:0] sha,
                                input logic [31:0] spa, input logic [31:0] tpa, input int len);
    bq_t q;
    logic [7:0] h[42];
    logic [47:0] src;
    src = 48'h02_00_00_00_00_99;
    for (int i = 0; i < 42; i++) h[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      h[i]      = dst[47-8*i -: 8];
      h[6+i]    = src[47-8*i -: 8];
      h[22+i]   = sha[47-8*i -: 8];
    end
    h[12] = et[15:8];  h[13] = et[7:0];
    h[14] = 8'h00;     h[15] = 8'h01;
    h[16] = 8'h08;     h[17] = 8'h00;
    h[18] = 8'd6;      h[19] = 8'd4;
    h[20] = op[15:8];  h[21] = op[7:0];
    for (int i = 0; i < 4; i++) begin
      h[28+i] = spa[31-8*i -: 8];
      h[38+i] = tpa[31-8*i -: 8];
    end
    for (int i = 0; i < len; i++) q.push_back(i < 42 ? h[i] : 8'h00);
    return q;
  endfunction

  // Reference: judge the whole frame at once from its field values.
  function automatic void model(input bq_t f, input bit err, output bit acc, output bit req,
                                output logic [47:0] mac, output logic [31:0] ip);
    logic [47:0] dst;
    logic [15:0] et, ht, pt, op;
    logic [31:0] tpa;
    acc = 1'b0; req = 1'b0; mac = '0; ip = '0;
    if (f.size() < 42) return;
    dst = {f[0], f[1], f[2], f[3], f[4], f[5]};
    et  = {f[12], f[13]};
    ht  = {f[14], f[15]};
    pt  = {f[16], f[17]};
    op  = {f[20], f[21]};
    tpa = {f[38], f[39], f[40], f[41]};
    mac = {f[22], f[23], f[24], f[25], f[26], f[27]};
    ip  = {f[28], f[29], f[30], f[31]};
    req = (op == 16'd1);
    acc = (dst == BC || dst == LMAC) && et == 16'h0806 && ht == 16'h0001 &&
          pt == 16'h0800 && f[18] == 8'd6 && f[19] == 8'd4 &&
          (op == 16'd1 || op == 16'd2) && tpa == LIP && !err;
  endfunction

  // Drives one frame starting at the current negedge; returns at the negedge
  // of the cycle after the last beat (the strobe cycle).
  task automatic send(input bq_t f, input bit err, input int gap_pct);
    for (int i = 0; i < f.size(); i++) begin
      for (int g = 0; i > 0 && g < 3 && $urandom_range(99) < gap_pct; g++) begin
        rx_valid = 1'b0; rx_data = 8'($urandom);
        rx_last = 1'($urandom); rx_err = 1'($urandom);
        @(negedge clk);
      end
      rx_valid = 1'b1; rx_data = f[i];
      rx_last  = (i == f.size() - 1);
      rx_err   = rx_last ? err : 1'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0;
  endtask

  task automatic expect_frame(input string nm, input bit acc, input bit req,
                              input logic [47:0] mac, input logic [31:0] ip);
    chk({nm, ".valid"}, 64'(arp_rx_valid), 64'(acc));
    chk({nm, ".drop"}, 64'(arp_drop), 64'(!acc));
    if (acc) begin
      chk({nm, ".is_req"}, 64'(arp_is_request), 64'(req));
      hold_mac = mac; hold_ip = ip;
      exp_acc_n++;
    end else exp_drop_n++;
    chk({nm, ".mac"}, 64'(arp_src_mac), 64'(hold_mac));
    chk({nm, ".ip"}, 64'(arp_src_ip), 64'(hold_ip));
  endtask

  task automatic settle(input string nm);
    @(negedge clk);
    chk({nm, ".strobe_low"}, 64'({arp_rx_valid, arp_drop, arp_is_request}), 64'(0));
  endtask

  typedef struct {
    logic [47:0] dst; logic [15:0] et; logic [15:0] op;
    logic [47:0] sha; logic [31:0] spa; logic [31:0] tpa;
    int len; bit err; bit acc; bit req;
  } vec_t;

  vec_t tbl[10];
  bq_t  f, f2;
  bit   m_acc, m_req;
  logic [47:0] m_mac;
  logic [31:0] m_ip;

  initial begin
    tbl[0] = '{BC,   16'h0806, 16'd1, 48'h000a35010203, 32'hc0a8010a, LIP, 42, 0, 1, 1};
    tbl[1] = '{LMAC, 16'h0806, 16'd2, 48'h001122aabbcc, 32'h0a000001, LIP, 60, 0, 1, 0};
    tbl[2] = '{BC,   16'h0800, 16'd1, 48'h111111111111, 32'h01010101, LIP, 60, 0, 0, 0};
    tbl[3] = '{BC,   16'h0806, 16'd1, 48'h222222222222, 32'h02020202, 32'hc0a80163, 60, 0, 0, 0};
    tbl[4] = '{BC,   16'h0806, 16'd1, 48'h333333333333, 32'h03030303, LIP, 30, 0, 0, 0};
    tbl[5] = '{48'h021122334456, 16'h0806, 16'd1, 48'h444444444444, 32'h04040404, LIP, 60, 0, 0, 0};
    tbl[6] = '{BC,   16'h0806, 16'd3, 48'h555555555555, 32'h05050505, LIP, 60, 0, 0, 0};
    tbl[7] = '{LMAC, 16'h0806, 16'd1, 48'h0a0b0c0d0e0f, 32'hac100001, LIP, 70, 0, 1, 1};
    tbl[8] = '{BC,   16'h0806, 16'd2, 48'h666666666666, 32'h06060606, LIP, 41, 0, 0, 0};
    tbl[9] = '{BC,   16'h0806, 16'd2, 48'h0000deadbeef, 32'hc0a80177, LIP, 42, 0, 1, 0};

    // Reset state.
    #12;
    chk("reset.outs", {arp_src_mac, 13'd0, arp_rx_valid, arp_is_request, arp_drop}, 64'(0));
    chk("reset.ip", 64'(arp_src_ip), 64'(0));
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
`ifdef ARP_RX_STATS_EN
    stat_clr = 1'b1; @(negedge clk); stat_clr = 1'b0;
`endif

    for (int i = 0; i < 10; i++) begin
      f = build(tbl[i].dst, tbl[i].et, tbl[i].op, tbl[i].sha, tbl[i].spa, tbl[i].tpa, tbl[i].len);
      send(f, tbl[i].err, 0);
      expect_frame($sformatf("tbl%0d", i), tbl[i].acc, tbl[i].req, tbl[i].sha, tbl[i].spa);
      settle($sformatf("tbl%0d", i));
    end

`ifdef ARP_RX_STATS_EN
    // Table gives 4 accepts and 6 drops since the clear.
    chk("stats.acc", 64'(stat_accept_cnt), 64'(4));
    chk("stats.drop", 64'(stat_drop_cnt), 64'(6));
`endif

    // rx_err on the last beat, then a good frame starting in the DONE cycle with gaps.
    f = build(BC, 16'h0806, 16'd1, 48'h777777777777, 32'h07070707, LIP, 42);
    send(f, 1'b1, 0);
    expect_frame("err", 1'b0, 1'b0, '0, '0);
    f2 = build(LMAC, 16'h0806, 16'd1, 48'h0a1b2c3d4e5f, 32'hc0a80155, LIP, 50);
    send(f2, 1'b0, 40);
    expect_frame("b2b", 1'b1, 1'b1, 48'h0a1b2c3d4e5f, 32'hc0a80155);
    settle("b2b");

    // Reset at byte 25 of a valid frame.
    f = build(BC, 16'h0806, 16'd1, 48'h888888888888, 32'h08080808, LIP, 42);
    for (int i = 0; i < 25; i++) begin
      rx_valid = 1'b1; rx_data = f[i]; rx_last = 1'b0; rx_err = 1'b0;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst.outs", {arp_src_mac, 13'd0, arp_rx_valid, arp_is_request, arp_drop}, 64'(0));
    chk("midrst.ip", 64'(arp_src_ip), 64'(0));
    hold_mac = '0; hold_ip = '0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst.nostrobe", 64'({arp_rx_valid, arp_drop}), 64'(0));
    send(f, 1'b0, 0);
    expect_frame("postrst", 1'b1, 1'b1, 48'h888888888888, 32'h08080808);
    settle("postrst");

`ifdef ARP_RX_STATS_EN
    // Clear in the same cycle as an accept strobe wins over the increment.
    send(f, 1'b0, 0);
    expect_frame("clr", 1'b1, 1'b1, 48'h888888888888, 32'h08080808);
    stat_clr = 1'b1; @(negedge clk); stat_clr = 1'b0;
    chk("stats.clr_acc", 64'(stat_accept_cnt), 64'(0));
    chk("stats.clr_drop", 64'(stat_drop_cnt), 64'(0));
`endif

    // Randomized frames against the reference model.
    for (int n = 0; n < 80; n++) begin
      int len, mi;
      logic [15:0] op;
      len = ($urandom_range(9) == 0) ? int'($urandom_range(41, 20)) : int'($urandom_range(70, 42));
      op  = $urandom_range(1) ? 16'd1 : 16'd2;
      f = build($urandom_range(1) ? BC : LMAC, 16'h0806, op,
                {16'($urandom), 32'($urandom)}, 32'($urandom), LIP, len);
      if ($urandom_range(1)) begin
        mi = int'($urandom_range(45));
        if (mi < f.size()) f[mi] = f[mi] ^ 8'($urandom_range(255, 1));
      end
      m_acc = 1'b0;
      model(f, ($urandom_range(9) == 0), m_acc, m_req, m_mac, m_ip);
      // Error flag is re-derived for the model and the drive from one draw.
      begin
        bit e;
        e = ($urandom_range(9) == 0);
        model(f, e, m_acc, m_req, m_mac, m_ip);
        send(f, e, int'($urandom_range(40)));
      end
      expect_frame($sformatf("rnd%0d", n), m_acc, m_req, m_mac, m_ip);
      if ($urandom_range(1)) settle($sformatf("rnd%0d", n));
    end

    repeat (3) @(negedge clk);
    chk("tot.valid", 64'(n_vld), 64'(exp_acc_n));
    chk("tot.drop", 64'(n_drop), 64'(exp_drop_n));
    chk("tot.exclusive", 64'(n_both), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
